// File: rtl/inputc_param.sv
// ---------------------------------------------------------------------------
// inputc_param
// Router input channel: one physical input port carrying NVC virtual
// channels. Each VC owns a DEPTH-entry FIFO and a small packet FSM that
// latches the lookahead route (output port + downstream VC) from the head
// flit. A round-robin selector offers one switch request per cycle to the
// switch allocator; granted flits leave through a registered output stage
// and return a one-cycle credit upstream.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset
//   idata    - incoming flit
//   ivalid   - idata valid this cycle
//   ivch     - VC the incoming flit targets
//   ordy     - per VC, FIFO has a free slot
//   ocredit  - per VC, one-cycle pulse for every flit popped
//   olck     - per VC, VC is inside a packet (ACTIVE)
//   ovf      - sticky, a flit was dropped because its FIFO was full
//   idn_rdy  - downstream VC ready, bit p*NVC+v is port p / VC v
//   req      - switch request from the selected VC
//   port     - requested output port
//   ovch     - requested downstream VC
//   grt      - allocator grant for the current request
//   odata    - registered outgoing flit
//   ovalid   - odata valid
// ---------------------------------------------------------------------------
module inputc_param #(
    parameter int DATAW = 32,
    parameter int NVC   = 2,
    parameter int DEPTH = 4,
    parameter int NPORT = 5,
    localparam int VCW   = (NVC > 1) ? $clog2(NVC) : 1,
    localparam int PORTW = $clog2(NPORT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATAW-1:0]       idata,
    input  logic                   ivalid,
    input  logic [VCW-1:0]         ivch,
    output logic [NVC-1:0]         ordy,
    output logic [NVC-1:0]         ocredit,
    output logic [NVC-1:0]         olck,
    output logic                   ovf,
    input  logic [NPORT*NVC-1:0]   idn_rdy,
    output logic                   req,
    output logic [PORTW-1:0]       port,
    output logic [VCW-1:0]         ovch,
    input  logic                   grt,
    output logic [DATAW-1:0]       odata,
    output logic                   ovalid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } vc_state_t;

    vc_state_t        state  [NVC];
    logic [DATAW-1:0] mem    [NVC][DEPTH];
    logic [AW-1:0]    rd_ptr [NVC];
    logic [AW-1:0]    wr_ptr [NVC];
    logic [CW-1:0]    count  [NVC];
    logic [PORTW-1:0] rport  [NVC];
    logic [VCW-1:0]   rvch   [NVC];
    logic [VCW-1:0]   ptr;

    logic [DATAW-1:0] front  [NVC];
    logic [1:0]       ftype  [NVC];
    logic [NVC-1:0]   nonempty;
    logic [NVC-1:0]   is_head;
    logic [NVC-1:0]   eligible;
    logic [NVC-1:0]   push;
    logic [NVC-1:0]   pop;
    logic [VCW-1:0]   sel;
    logic             grant;
    logic             drop;

    // Per-VC status decoded from registered state. A VC is eligible only
    // when its latched route points at a real downstream VC that is ready;
    // a route outside the port/VC range is never eligible.
    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            front[v]    = mem[v][rd_ptr[v]];
            ftype[v]    = front[v][DATAW-1 -: 2];
            nonempty[v] = (count[v] != '0);
            is_head[v]  = (ftype[v] == 2'b00) || (ftype[v] == 2'b01);
            ordy[v]     = (count[v] < CW'(DEPTH));
            olck[v]     = (state[v] == ACTIVE);
            eligible[v] = 1'b0;
            if (state[v] == ACTIVE && nonempty[v] &&
                int'(rport[v]) < NPORT && int'(rvch[v]) < NVC) begin
                eligible[v] = idn_rdy[int'(rport[v]) * NVC + int'(rvch[v])];
            end
        end
    end

    // Round-robin pick: scan from the VC after the last winner and take
    // the first eligible one.
    always_comb begin
        req = 1'b0;
        sel = '0;
        for (int i = 1; i <= NVC; i++) begin
            if (!req && eligible[(int'(ptr) + i) % NVC]) begin
                req = 1'b1;
                sel = VCW'((int'(ptr) + i) % NVC);
            end
        end
        port  = req ? rport[sel] : '0;
        ovch  = req ? rvch[sel]  : '0;
        grant = req && grt;
    end

    // Pops come from a granted VC or from discarding a stray body/tail that
    // reached the front of an idle VC. A push is accepted when there is room,
    // or when the full FIFO is popping in the same cycle.
    always_comb begin
        drop = 1'b0;
        for (int v = 0; v < NVC; v++) begin
            pop[v] = (grant && sel == VCW'(v)) ||
                     (state[v] == IDLE && nonempty[v] && !is_head[v]);
            push[v] = ivalid && (ivch == VCW'(v)) && (ordy[v] || pop[v]);
            if (ivalid && (ivch == VCW'(v)) && !ordy[v] && !pop[v]) begin
                drop = 1'b1;
            end
        end
    end

    // FIFO storage carries no reset; emptiness is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NVC; v++) begin
            if (push[v]) begin
                mem[v][wr_ptr[v]] <= idata;
            end
        end
    end

    // FIFO pointers, per-VC packet FSMs, arbitration pointer and the
    // registered output stage. Credits are registered alongside odata so
    // they appear one cycle after the pop decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NVC; v++) begin
                state[v]  <= IDLE;
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                count[v]  <= '0;
                rport[v]  <= '0;
                rvch[v]   <= '0;
            end
            ptr     <= VCW'(NVC - 1);
            ovf     <= 1'b0;
            odata   <= '0;
            ovalid  <= 1'b0;
            ocredit <= '0;
        end else begin
            for (int v = 0; v < NVC; v++) begin
                if (push[v]) begin
                    wr_ptr[v] <= wr_ptr[v] + AW'(1);
                end
                if (pop[v]) begin
                    rd_ptr[v] <= rd_ptr[v] + AW'(1);
                end
                case ({push[v], pop[v]})
                    2'b10:   count[v] <= count[v] + CW'(1);
                    2'b01:   count[v] <= count[v] - CW'(1);
                    default: count[v] <= count[v];
                endcase
                case (state[v])
                    IDLE: begin
                        if (nonempty[v] && is_head[v]) begin
                            rport[v] <= front[v][PORTW-1:0];
                            rvch[v]  <= front[v][PORTW+VCW-1:PORTW];
                            state[v] <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (pop[v] && (ftype[v] == 2'b00 || ftype[v] == 2'b11)) begin
                            state[v] <= IDLE;
                        end
                    end
                    default: state[v] <= IDLE;
                endcase
            end
            if (drop) begin
                ovf <= 1'b1;
            end
            if (grant) begin
                ptr <= sel;
            end
            ovalid  <= grant;
            odata   <= grant ? front[sel] : '0;
            ocredit <= pop;
        end
    end

endmodule
